// File: rtl/sprite_plotter.sv
// Sprite pixel-stream engine: expands one object draw/erase/move request into
// row-major pixel writes for the VGA adapter, with screen clipping.
module sprite_plotter #(
   parameter int unsigned SPRITE_W  = 4,
   parameter int unsigned SPRITE_H  = 4,
   parameter logic [2:0]  BG_COLOUR = 3'b000,
   parameter int unsigned X_MAX     = 159,
   parameter int unsigned Y_MAX     = 119
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic [1:0] mode,
   input  logic [7:0] x_in,
   input  logic [6:0] y_in,
   input  logic [2:0] colour_in,
   output logic       ready,
   output logic       done,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot
);

   localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

   typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [7:0]      base_x_q, base_x_d;
   logic [6:0]      base_y_q, base_y_d;
   logic [7:0]      lat_x_q, lat_x_d;
   logic [6:0]      lat_y_q, lat_y_d;
   logic [2:0]      lat_colour_q, lat_colour_d;
   logic            move_pend_q, move_pend_d;
   logic            prev_valid_q, prev_valid_d;
   logic [7:0]      prev_x_q, prev_x_d;
   logic [6:0]      prev_y_q, prev_y_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic [7:0]      x_q, x_d;
   logic [6:0]      y_q, y_d;
   logic [2:0]      colour_q, colour_d;
   logic            plot_q, plot_d;

   logic            emit;
   logic            emit_erase;
   logic            last_pix;
   logic [8:0]      sum_x;
   logic [7:0]      sum_y;

   assign last_pix = (col_q == CW'(SPRITE_W - 1)) && (row_q == RW'(SPRITE_H - 1));

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      base_x_d     = base_x_q;
      base_y_d     = base_y_q;
      lat_x_d      = lat_x_q;
      lat_y_d      = lat_y_q;
      lat_colour_d = lat_colour_q;
      move_pend_d  = move_pend_q;
      prev_valid_d = prev_valid_q;
      prev_x_d     = prev_x_q;
      prev_y_d     = prev_y_q;
      emit         = 1'b0;
      emit_erase   = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (req) begin
               lat_x_d      = x_in;
               lat_y_d      = y_in;
               lat_colour_d = colour_in;
               base_x_d     = x_in;
               base_y_d     = y_in;
               col_d        = '0;
               row_d        = '0;
               move_pend_d  = 1'b0;
               emit         = 1'b1;
               case (mode)
                  2'b01: begin
                     state_d    = StErase;
                     emit_erase = 1'b1;
                  end
                  2'b10: begin
                     if (prev_valid_q) begin
                        state_d     = StErase;
                        emit_erase  = 1'b1;
                        move_pend_d = 1'b1;
                        base_x_d    = prev_x_q;
                        base_y_d    = prev_y_q;
                     end else begin
                        state_d = StDraw;
                     end
                  end
                  default: state_d = StDraw;
               endcase
            end
         end
         StErase, StDraw: begin
            if (last_pix) begin
               if (state_q == StErase && move_pend_q) begin
                  // Erase of the old block done; draw pass follows with no gap.
                  state_d     = StDraw;
                  move_pend_d = 1'b0;
                  base_x_d    = lat_x_q;
                  base_y_d    = lat_y_q;
                  col_d       = '0;
                  row_d       = '0;
                  emit        = 1'b1;
               end else begin
                  state_d = StDone;
                  if (state_q == StDraw) begin
                     prev_valid_d = 1'b1;
                     prev_x_d     = lat_x_q;
                     prev_y_d     = lat_y_q;
                  end else begin
                     prev_valid_d = 1'b0;
                  end
               end
            end else begin
               emit       = 1'b1;
               emit_erase = (state_q == StErase);
               if (col_q == CW'(SPRITE_W - 1)) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered pixel outputs are computed from the next-cycle base and counters.
   always_comb begin
      sum_x    = {1'b0, base_x_d} + 9'(col_d);
      sum_y    = {1'b0, base_y_d} + 8'(row_d);
      plot_d   = emit && (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));
      x_d      = emit ? sum_x[7:0] : x_q;
      y_d      = emit ? sum_y[6:0] : y_q;
      colour_d = colour_q;
      if (emit) begin
         colour_d = emit_erase ? BG_COLOUR : lat_colour_d;
      end
      done_d   = (state_d == StDone);
      ready_d  = (state_d == StIdle) || (state_d == StDone);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         col_q        <= '0;
         row_q        <= '0;
         base_x_q     <= '0;
         base_y_q     <= '0;
         lat_x_q      <= '0;
         lat_y_q      <= '0;
         lat_colour_q <= '0;
         move_pend_q  <= 1'b0;
         prev_valid_q <= 1'b0;
         prev_x_q     <= '0;
         prev_y_q     <= '0;
         ready_q      <= 1'b1;
         done_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         colour_q     <= '0;
         plot_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         base_x_q     <= base_x_d;
         base_y_q     <= base_y_d;
         lat_x_q      <= lat_x_d;
         lat_y_q      <= lat_y_d;
         lat_colour_q <= lat_colour_d;
         move_pend_q  <= move_pend_d;
         prev_valid_q <= prev_valid_d;
         prev_x_q     <= prev_x_d;
         prev_y_q     <= prev_y_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
         x_q          <= x_d;
         y_q          <= y_d;
         colour_q     <= colour_d;
         plot_q       <= plot_d;
      end
   end

   assign ready  = ready_q;
   assign done   = done_q;
   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: a per-cycle expected stream is built from
// request semantics and compared by an independent monitor.
module tb_sprite_plotter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] x_in = '0;
   logic [6:0] y_in = '0;
   logic [2:0] colour_in = '0;
   logic       ready, done, plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   sprite_plotter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .mode      (mode),
      .x_in      (x_in),
      .y_in      (y_in),
      .colour_in (colour_in),
      .ready     (ready),
      .done      (done),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         pix;
      bit         plot;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      bit         done;
      bit         rdy;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;
   bit   m_pv = 1'b0;
   int   m_px = 0;
   int   m_py = 0;

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
      end
   endtask

   function automatic void push_pass(input int bx, input int by, input logic [2:0] c);
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            exp_t e;
            int   xx = bx + k;
            int   yy = by + r;
            e.pix  = 1'b1;
            e.plot = (xx <= 159) && (yy <= 119);
            e.x    = 8'(xx);
            e.y    = 7'(yy);
            e.c    = c;
            e.done = 1'b0;
            e.rdy  = 1'b0;
            exp_q.push_back(e);
         end
      end
   endfunction

   function automatic void push_req(input logic [1:0] m, input int xi, input int yi,
                                    input logic [2:0] ci);
      exp_t d;
      if (m == 2'b01) begin
         push_pass(xi, yi, 3'b000);
         m_pv = 1'b0;
      end else begin
         if (m == 2'b10 && m_pv) push_pass(m_px, m_py, 3'b000);
         push_pass(xi, yi, ci);
         m_pv = 1'b1;
         m_px = xi;
         m_py = yi;
      end
      d.pix  = 1'b0;
      d.plot = 1'b0;
      d.x    = '0;
      d.y    = '0;
      d.c    = '0;
      d.done = 1'b1;
      d.rdy  = 1'b1;
      exp_q.push_back(d);
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("plot", int'(plot), int'(e.plot));
            chk("done", int'(done), int'(e.done));
            chk("ready", int'(ready), int'(e.rdy));
            if (e.pix) begin
               chk("x", int'(x), int'(e.x));
               chk("y", int'(y), int'(e.y));
               chk("colour", int'(colour), int'(e.c));
            end
         end else begin
            chk("idle_plot", int'(plot), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_ready", int'(ready), 1);
         end
      end
   end

   // Called shortly after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [1:0] m, input logic [7:0] xi, input logic [6:0] yi,
                        input logic [2:0] ci, input bit keep_req);
      int  waited = 0;
      bit  acc = 1'b0;
      mode      = m;
      x_in      = xi;
      y_in      = yi;
      colour_in = ci;
      req       = 1'b1;
      while (!acc) begin
         @(negedge clk);
         if (ready) acc = 1'b1;
         else if (++waited > 300) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 300 cycles");
            req = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      push_req(m, int'(xi), int'(yi), ci);
      req = keep_req;
      if (!keep_req) begin
         mode      = 2'($urandom);
         x_in      = 8'($urandom);
         y_in      = 7'($urandom);
         colour_in = 3'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst_ready", int'(ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_plot", int'(plot), 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_colour", int'(colour), 0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1 mon_en = 1'b1;

      issue(2'b00, 8'd10, 7'd20, 3'b111, 1'b0); wait_idle();
      issue(2'b01, 8'd10, 7'd20, 3'b101, 1'b0); wait_idle();
      issue(2'b10, 8'd30, 7'd40, 3'b101, 1'b0); wait_idle();
      issue(2'b00, 8'd10, 7'd20, 3'b111, 1'b0); wait_idle();
      issue(2'b10, 8'd12, 7'd20, 3'b010, 1'b0); wait_idle();
      issue(2'b00, 8'd158, 7'd118, 3'b100, 1'b0); wait_idle();

      // Request during a busy stream must be dropped.
      issue(2'b00, 8'd50, 7'd60, 3'b011, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      req  = 1'b1;
      x_in = 8'd99;
      mode = 2'b01;
      @(posedge clk);
      #1 req = 1'b0;
      wait_idle();

      // Held request is taken on the done/ready cycle.
      issue(2'b00, 8'd20, 7'd30, 3'b001, 1'b1);
      issue(2'b10, 8'd24, 7'd30, 3'b110, 1'b1);
      issue(2'b11, 8'd0, 7'd0, 3'b011, 1'b0);
      wait_idle();

      // Reset during the erase pass of a move aborts and clears history.
      issue(2'b00, 8'd40, 7'd50, 3'b011, 1'b0); wait_idle();
      issue(2'b10, 8'd44, 7'd50, 3'b101, 1'b0);
      repeat (6) @(posedge clk);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      m_pv = 1'b0;
      #1;
      chk("abort_plot", int'(plot), 0);
      chk("abort_ready", int'(ready), 1);
      chk("abort_done", int'(done), 0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      issue(2'b10, 8'd60, 7'd70, 3'b010, 1'b0); wait_idle();

      for (int i = 0; i < 40; i++) begin
         logic [1:0] m;
         logic [7:0] xi;
         logic [6:0] yi;
         bit         hold;
         m    = 2'($urandom_range(0, 3));
         xi   = 8'($urandom_range(0, 255));
         yi   = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 2) == 0) xi = 8'($urandom_range(150, 163));
         if ($urandom_range(0, 2) == 0) yi = 7'($urandom_range(110, 123));
         hold = 1'($urandom_range(0, 1));
         issue(m, xi, yi, 3'($urandom), hold);
         if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      req = 1'b0;
      wait_idle();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
